// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter: per-source result FIFOs, round-robin grant, registered broadcast
module cdb_arbiter #(
  parameter int N_SRC      = 4,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*TAG_W-1:0]    src_id,
  input  logic [N_SRC*DATA_W-1:0]   src_val,
  output logic [N_SRC-1:0]          src_ready,
  output logic                      shared_cdb_transmit,
  output logic [TAG_W-1:0]          shared_cdb_id,
  output logic [DATA_W-1:0]         shared_cdb_val,
  output logic                      src_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GNT_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [TAG_W-1:0]  id_mem_q  [N_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] val_mem_q [N_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q  [N_SRC];
  logic [PTR_W-1:0]  wr_ptr_q  [N_SRC];
  logic [CNT_W-1:0]  count_q   [N_SRC];
  logic [GNT_W-1:0]  last_grant_q;
  logic              cdb_tx_q;
  logic [TAG_W-1:0]  cdb_id_q, cdb_id_d;
  logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
  logic              overflow_q;

  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;
  logic [GNT_W-1:0]  winner;
  logic [GNT_W-1:0]  cand;
  logic              found;
  int                slot;

  // Ready depends on stored occupancy only, so a full FIFO stays not-ready while being popped.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = (count_q[i] < DEPTH_C);
    end
    push = src_valid & src_ready;
  end

  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    cand   = '0;
    slot   = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      slot = int'(last_grant_q) + k;
      if (slot >= N_SRC) slot = slot - N_SRC;
      cand = GNT_W'(slot);
      if (!found && (count_q[cand] != '0)) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      pop[i] = found && (winner == GNT_W'(i));
    end
    cdb_id_d  = found ? id_mem_q[winner][rd_ptr_q[winner]]  : '0;
    cdb_val_d = found ? val_mem_q[winner][rd_ptr_q[winner]] : '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (!flush && push[i]) begin
        id_mem_q[i][wr_ptr_q[i]]  <= src_id[i*TAG_W +: TAG_W];
        val_mem_q[i][wr_ptr_q[i]] <= src_val[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      last_grant_q <= GNT_W'(N_SRC - 1);
      cdb_tx_q     <= 1'b0;
      cdb_id_q     <= '0;
      cdb_val_q    <= '0;
      overflow_q   <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      cdb_tx_q  <= 1'b0;
      cdb_id_q  <= '0;
      cdb_val_q <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + CNT_W'(1);
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - CNT_W'(1);
      end
      if (found) last_grant_q <= winner;
      cdb_tx_q  <= found;
      cdb_id_q  <= cdb_id_d;
      cdb_val_q <= cdb_val_d;
      if (|(src_valid & ~src_ready)) overflow_q <= 1'b1;
    end
  end

  assign shared_cdb_transmit = cdb_tx_q;
  assign shared_cdb_id       = cdb_id_q;
  assign shared_cdb_val      = cdb_val_q;
  assign src_overflow        = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 8;
  localparam int D  = 2;

  typedef logic [TW+DW-1:0] ent_t;
  typedef logic [TW+DW:0]   bc_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N*TW-1:0] src_id;
  logic [N*DW-1:0] src_val;
  logic [N-1:0]    src_ready;
  logic            shared_cdb_transmit;
  logic [TW-1:0]   shared_cdb_id;
  logic [DW-1:0]   shared_cdb_val;
  logic            src_overflow;

  cdb_arbiter #(.N_SRC(N), .TAG_W(TW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_id(src_id), .src_val(src_val),
    .src_ready(src_ready),
    .shared_cdb_transmit(shared_cdb_transmit),
    .shared_cdb_id(shared_cdb_id), .shared_cdb_val(shared_cdb_val),
    .src_overflow(src_overflow)
  );

  always #5 clk = ~clk;

  ent_t mq [N][$];
  bc_t  exp_q [$];
  int   last_g;
  bit   m_ovf;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bc_t  mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one arbitration edge judged on queue contents before the edge.
  task automatic model_step(input logic [N-1:0] v, input logic [N*TW-1:0] ids,
                            input logic [N*DW-1:0] vals, input logic fl);
    logic [N-1:0] rdy;
    bit   got;
    int   idx;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
    if (fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_q.push_back('0);
      return;
    end
    got = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (last_g + k) % N;
      if (!got && mq[idx].size() > 0) begin
        got = 1'b1;
        exp_q.push_back({1'b1, mq[idx].pop_front()});
        last_g = idx;
      end
    end
    if (!got) exp_q.push_back('0);
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (rdy[i]) mq[i].push_back({ids[i*TW +: TW], vals[i*DW +: DW]});
        else        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*TW-1:0] ids,
                       input logic [N*DW-1:0] vals, input logic fl);
    logic [N-1:0] er;
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) er[i] = (mq[i].size() < D);
    chk("src_ready", 32'(src_ready), 32'(er));
    chk("src_overflow", 32'(src_overflow), 32'(m_ovf));
    src_valid = v;
    src_id    = ids;
    src_val   = vals;
    flush     = fl;
    model_step(v, ids, vals, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en    = 1'b0;
    rst       = 1'b1;
    src_valid = '0;
    src_id    = '0;
    src_val   = '0;
    flush     = 1'b0;
    #1;
    chk("rst_transmit", 32'(shared_cdb_transmit), 32'd0);
    chk("rst_id_val", {shared_cdb_id, shared_cdb_val}, 32'd0);
    chk("rst_ready", 32'(src_ready), 32'hF);
    chk("rst_overflow", 32'(src_overflow), 32'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) mq[i].delete();
    last_g = N - 1;
    m_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cdb_broadcast", {shared_cdb_transmit, shared_cdb_id, shared_cdb_val}, 32'(mon_e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]    rv;
    logic [N*TW-1:0] rid;
    logic [N*DW-1:0] rval;
    rst = 1'b1; flush = 1'b0; src_valid = '0; src_id = '0; src_val = '0;
    do_reset();

    cycle(4'b0001, 16'h0003, 32'h0000_00A5, 1'b0);
    idle(4);

    cycle(4'b1111, 16'h4321, 32'h4433_2211, 1'b0);
    idle(5);
    cycle(4'b0011, 16'h0065, 32'h0000_6655, 1'b0);
    idle(3);

    cycle(4'b0100, 16'h0700, 32'h0071_0000, 1'b0);
    cycle(4'b0100, 16'h0800, 32'h0082_0000, 1'b0);
    cycle(4'b0100, 16'h0900, 32'h0093_0000, 1'b0);
    idle(4);

    cycle(4'b0010, 16'h00A0, 32'h0000_A100, 1'b0);
    cycle(4'b0010, 16'h00B0, 32'h0000_B200, 1'b0);
    cycle(4'b1000, 16'hC000, 32'hC300_0000, 1'b1);
    idle(3);

    for (int c = 0; c < 8; c++) begin
      cycle((c == 2) ? 4'b1001 : 4'b0001, {4'hE, 12'(c)}, {8'hEE, 16'h0, 8'(8'h10 + c)}, 1'b0);
    end
    idle(6);

    cycle(4'b1111, 16'h8765, 32'h8877_6655, 1'b0);
    idle(1);
    do_reset();
    cycle(4'b0011, 16'h00DC, 32'h0000_DDCC, 1'b0);
    idle(3);

    for (int c = 0; c < 400; c++) begin
      rv   = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      rid  = N*TW'($urandom);
      rval = {$urandom};
      cycle(rv, rid, rval, $urandom_range(0, 31) == 0);
    end
    idle(8);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
